uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arb_if.sv | 29 ++
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arb.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults
// for the uart_tx round-robin arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 4096;

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester bus plus the
// uart_tx side-band, bundled for the arbiter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic                          busy;
  logic                          newd;
  logic [DATA_WIDTH-1:0]         din;
  logic                          tx_line;
  logic                          done_tx;

  modport slave (
    input  req, req_data, tx_line, done_tx,
    output gnt, done, err, busy, newd, din
  );

  modport master (
    output req, req_data, tx_line, done_tx,
    input  gnt, done, err, busy, newd, din
  );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotating-priority search,
// first set request at or after ptr_i.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            k
  );
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(NUM_REQ))
      s = s - (IW+1)'(NUM_REQ);
    return s[IW-1:0];
  endfunction

  // Walk offsets high to low so the smallest
  // offset from ptr_i is the one that sticks.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[wrap(ptr_i, k)]) begin
        valid_o = 1'b1;
        idx_o   = wrap(ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx among NUM_REQ
// requesters, round-robin, with a per-byte watchdog.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic         clk,
  input logic         reset,
  uart_tx_arb_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         cur_q, cur_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  err_q, err_d;
  logic                  newd_q, newd_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  dtx_q;

  logic          pick_v;
  logic [IW-1:0] pick_idx;
  logic          dtx_rise;
  logic          tmo;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_v),
    .idx_o   (pick_idx)
  );

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] i
  );
    if (i == IW'(NUM_REQ - 1))
      return '0;
    return i + IW'(1);
  endfunction

  assign dtx_rise = bus.done_tx & ~dtx_q;
  assign tmo      = (timer_q == TW'(TIMEOUT - 1));

  // Next-state, grant/launch and completion logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    newd_d  = newd_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        newd_d = 1'b0;
        if (pick_v) begin
          state_d         = LAUNCH;
          cur_d           = pick_idx;
          din_d           = bus.req_data[
            pick_idx*DATA_WIDTH +: DATA_WIDTH];
          gnt_d[pick_idx] = 1'b1;
          timer_d         = '0;
          newd_d          = 1'b1;
        end
      end
      LAUNCH: begin
        timer_d = timer_q + TW'(1);
        if (tmo) begin
          done_d[cur_q] = 1'b1;
          err_d         = 1'b1;
          newd_d        = 1'b0;
          ptr_d         = nxt(cur_q);
          state_d       = IDLE;
        end else if (!bus.tx_line) begin
          newd_d  = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + TW'(1);
        if (dtx_rise) begin
          done_d[cur_q] = 1'b1;
          newd_d        = 1'b0;
          ptr_d         = nxt(cur_q);
          state_d       = IDLE;
        end else if (tmo) begin
          done_d[cur_q] = 1'b1;
          err_d         = 1'b1;
          newd_d        = 1'b0;
          ptr_d         = nxt(cur_q);
          state_d       = IDLE;
        end
      end
      default: begin
        newd_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, sync active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      newd_q  <= 1'b0;
      din_q   <= '0;
      dtx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      newd_q  <= newd_d;
      din_q   <= din_d;
      dtx_q   <= bus.done_tx;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.newd = newd_q;
  assign bus.din  = din_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: grant-order table plus corner
// sequences, with a behavioural uart_tx model.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TO  = 64;
  localparam int BIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  uart_tx_arb #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // uart_tx model: start on newd, 10-bit frame,
  // one-cycle done_tx; dead keeps line idle.
  logic       dead = 1'b0;
  logic       force_dtx = 1'b0;
  logic       dtx_r;
  int         m_st, m_cnt, m_bit;
  logic [9:0] shreg;
  logic [9:0] rx_bits;

  assign bus.done_tx = dtx_r | force_dtx;

  always @(posedge clk) begin
    if (!reset || dead) begin
      bus.tx_line <= 1'b1;
      dtx_r       <= 1'b0;
      m_st        <= 0;
      m_cnt       <= 0;
      m_bit       <= 0;
    end else begin
      case (m_st)
        0: if (bus.newd) begin
          shreg       <= {1'b1, bus.din, 1'b0};
          bus.tx_line <= 1'b0;
          m_st        <= 1;
          m_cnt       <= 0;
          m_bit       <= 0;
        end
        1: begin
          if (m_cnt == 1)
            rx_bits[m_bit] <= bus.tx_line;
          if (m_cnt == BIT - 1) begin
            m_cnt <= 0;
            if (m_bit == 9) begin
              m_st <= 2;
            end else begin
              m_bit       <= m_bit + 1;
              bus.tx_line <= shreg[m_bit+1];
            end
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        2: begin
          dtx_r       <= 1'b1;
          bus.tx_line <= 1'b1;
          m_st        <= 3;
        end
        default: begin
          dtx_r <= 1'b0;
          m_st  <= 0;
        end
      endcase
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] b;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   cyc = 0;
  int   gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: gnt checked against the head,
  // done pops it and checks frame or timeout.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.gnt != '0) begin
        if (sb.size() == 0) begin
          bad("unexpected_gnt");
        end else begin
          chk("gnt_idx", bus.gnt, 1 << sb[0].idx);
          chk("gnt_din", bus.din, sb[0].b);
          chk("gnt_busy", bus.busy, 1);
          gnt_cyc = cyc;
        end
      end
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          bad("unexpected_done");
        end else begin
          x = sb.pop_front();
          chk("done_idx", bus.done, 1 << x.idx);
          chk("done_err", bus.err, x.e);
          if (x.e) begin
            chk("tmo_latency", cyc - gnt_cyc, TO);
            chk("tmo_newd", bus.newd, 0);
          end else begin
            chk("frame", rx_bits, {1'b1, x.b, 1'b0});
          end
        end
      end else if (bus.err) begin
        bad("err_without_done");
      end
    end
  end

  task automatic push(input int idx,
                      input logic [31:0] data,
                      input logic e);
    exp_t t;
    t.idx = idx;
    t.b   = data[idx*8 +: 8];
    t.e   = e;
    sb.push_back(t);
  endtask

  task automatic wait_done(input int n,
                           input int bound);
    int got = 0;
    int c   = 0;
    while (got < n && c < bound) begin
      @(negedge clk);
      c++;
      if (bus.done != '0) got++;
    end
    if (got < n) begin
      bad("done_wait_expired");
      sb.delete();
    end
    bus.req = '0;
  endtask

  task automatic wait_gnt(input int bound);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.gnt == '0 && c < bound);
    if (bus.gnt == '0) bad("gnt_wait_expired");
  endtask

  task automatic chk_idle_out(input string nm);
    chk({nm, "_gnt"},  bus.gnt, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_err"},  bus.err, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_newd"}, bus.newd, 0);
    chk({nm, "_din"},  bus.din, 0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          n;
    logic [9:0]  seq;
  } row_t;

  row_t rows[6];
  int   premature = 0;
  logic [31:0] d;

  initial begin
    // seq holds expected grant indices, 2 bits each,
    // first grant in the low bits.
    rows[0] = '{4'b1111, 32'h44332211, 5, 10'h0E4};
    rows[1] = '{4'b0001, 32'h000000A5, 1, 10'h000};
    rows[2] = '{4'b0010, 32'h00005A00, 1, 10'h001};
    rows[3] = '{4'b0011, 32'h0000C33C, 2, 10'h004};
    rows[4] = '{4'b1000, 32'h7E000000, 3, 10'h03F};
    rows[5] = '{4'b0110, 32'h00F00F00, 3, 10'h019};

    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    chk_idle_out("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      bus.req_data = rows[r].data;
      for (int k = 0; k < rows[r].n; k++)
        push(rows[r].seq[2*k +: 2], rows[r].data, 1'b0);
      bus.req = rows[r].req;
      wait_done(rows[r].n, 120 * rows[r].n);
      repeat (3) @(negedge clk);
      chk("row_drained", sb.size(), 0);
    end

    // Watchdog abort on requester 1.
    dead = 1'b1;
    d = 32'h00009900;
    bus.req_data = d;
    push(1, d, 1'b1);
    bus.req = 4'b0010;
    wait_done(1, 200);
    dead = 1'b0;
    repeat (2) @(negedge clk);

    // Pointer moved past 1: 2 wins over 0 and 1.
    d = 32'h00123456;
    bus.req_data = d;
    push(2, d, 1'b0);
    bus.req = 4'b0111;
    wait_done(1, 200);
    repeat (2) @(negedge clk);

    // Request and data drop after grant; a short
    // request from 3 while busy is never granted.
    d = 32'h00BB0000;
    bus.req_data = d;
    push(2, d, 1'b0);
    bus.req = 4'b0100;
    wait_gnt(50);
    bus.req = '0;
    bus.req_data = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    bus.req = 4'b1000;
    repeat (5) @(negedge clk);
    bus.req = '0;
    wait_done(1, 200);
    repeat (5) @(negedge clk);
    chk("drop_drained", sb.size(), 0);

    // Stale done_tx high across launch.
    force_dtx = 1'b1;
    d = 32'h00000081;
    bus.req_data = d;
    repeat (2) @(negedge clk);
    push(0, d, 1'b0);
    bus.req = 4'b0001;
    wait_gnt(50);
    bus.req = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done != '0) premature++;
    end
    force_dtx = 1'b0;
    chk("stale_no_done", premature, 0);
    wait_done(1, 200);
    repeat (2) @(negedge clk);

    // Reset in WAIT_DONE, then a fresh grant.
    d = 32'h00004D00;
    bus.req_data = d;
    push(1, d, 1'b0);
    bus.req = 4'b0010;
    wait_gnt(50);
    repeat (8) @(negedge clk);
    chk("wd_busy_newd", {bus.busy, bus.newd}, 2'b10);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_out("midreset");
    sb.delete();
    d = 32'h00E70000;
    bus.req_data = d;
    bus.req = 4'b0100;
    reset = 1'b1;
    push(2, d, 1'b0);
    wait_done(1, 200);

    repeat (3) @(negedge clk);
    chk("final_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
